// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Per-cycle command to the IF/ID register.
  typedef enum logic [1:0] {
    IFID_HOLD       = 2'd0,
    IFID_LOAD       = 2'd1,
    IFID_BUBBLE     = 2'd2,
    IFID_INVALIDATE = 2'd3
  } ifid_op_e;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, insert a NOP bubble,
// or just drop its valid bit.
module fetch_if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  ifid_op_e           op,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
      valid       <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          instruction <= instr_in;
          pc          <= pc_in;
          valid       <= 1'b1;
        end
        IFID_BUBBLE: begin
          instruction <= NOP_INSTR;
          valid       <= 1'b0;
        end
        IFID_INVALIDATE: valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: FSM, PC mux and optional perf counters (FETCH_PERF_CNT_EN).
// state_dbg exposes the FSM state for checkers.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(5)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               done,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
  output fetch_state_e       state_dbg
);

  // Handshake: if_id_valid qualifies if_id_* every cycle; there is no ready,
  // decode applies back-pressure with stall, which freezes pc and if_id_*.
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              done_q, done_d;
  logic              fetch_inc, stall_inc;
  ifid_op_e          ifid_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = 1'b0;
    fetch_inc = 1'b0;
    stall_inc = 1'b0;
    ifid_op   = IFID_HOLD;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
          ifid_op = IFID_INVALIDATE;
          if (branch_taken) pc_d = branch_target;
        end else if (branch_taken) begin
          // A redirect outranks both stall and the end-of-program check.
          pc_d    = branch_target;
          ifid_op = IFID_BUBBLE;
        end else if (stall) begin
          stall_inc = 1'b1;
        end else begin
          ifid_op   = IFID_LOAD;
          fetch_inc = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
          if (pc_q == LAST_PC) begin
            state_d = HALT;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        ifid_op = IFID_INVALIDATE;
        if (branch_taken) pc_d = branch_target;
        if (start) state_d = RUN;
      end
    endcase
  end

  fetch_if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .op          (ifid_op),
    .instr_in    (imem_instruction),
    .pc_in       (pc_q),
    .instruction (if_id_instruction),
    .pc          (if_id_pc),
    .valid       (if_id_valid)
  );

  assign imem_address = pc_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_inc && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt  = fetch_inc ^ stall_inc;
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cycles push expected IF/ID contents into
// a queue; a monitor pops one entry after every edge and compares.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, stall, branch_taken;
  logic [31:0] branch_target, imem_address, imem_instruction;
  logic [31:0] if_id_instruction, if_id_pc, fetch_count, stall_count;
  logic        if_id_valid, done;
  fetch_state_e state_dbg;

  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .halt_req          (halt_req),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .done              (done),
    .fetch_count       (fetch_count),
    .stall_count       (stall_count),
    .state_dbg         (state_dbg)
  );

  // Instruction memory: word at address a is C0DE_0000 ^ a.
  assign imem_instruction = 32'hC0DE_0000 ^ imem_address;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record the IF/ID contents expected after the edge.
  task automatic cyc(input logic s, input logic h, input logic st, input logic b,
                     input logic [31:0] tgt, input logic ev, input logic [31:0] ein,
                     input logic [31:0] epc);
    @(negedge clk);
    rst           = 1'b0;
    start         = s;
    halt_req      = h;
    stall         = st;
    branch_taken  = b;
    branch_target = tgt;
    exp_q.push_back({ev, ein, epc});
    @(posedge clk);
    #2;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst          = 1'b1;
    start        = 1'b0;
    halt_req     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    exp_q.push_back({1'b0, 32'h0, 32'h0});
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] p);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000 | p, p);
  endtask

  // Monitor: compares IF/ID against the queue head once per cycle.
  initial begin
    logic [64:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (if_id_valid !== e[64] || if_id_instruction !== e[63:32] ||
            (e[64] && if_id_pc !== e[31:0])) begin
          errors++;
          $display("FAIL if_id: got valid=%b instr=%h pc=%h expected valid=%b instr=%h pc=%h",
                   if_id_valid, if_id_instruction, if_id_pc, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // Reset state, then a straight run to auto-halt.
    do_rst();
    do_rst();
    chk("rst_pc", imem_address, 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk("rst_stall_count", stall_count, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("idle_stall_ignored", 32'(state_dbg), 32'(IDLE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("start_run", 32'(state_dbg), 32'(RUN));
    for (int p = 0; p <= 5; p++) fetch(32'(p));
    chk("auto_halt_done", 32'(done), 32'h1);
    chk("auto_halt_state", 32'(state_dbg), 32'(HALT));
    chk("auto_halt_pc", imem_address, 32'h6);
    chk("auto_halt_fetch_count", fetch_count, CNT_ON ? 32'd6 : 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0005, 32'h5);
    chk("done_pulse_end", 32'(done), 32'h0);
    chk("halt_pc_hold", imem_address, 32'h6);

    // Three-cycle stall at pc=2.
    do_rst();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch(32'h0);
    fetch(32'h1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE_0001, 32'h1);
    chk("stall_pc", imem_address, 32'h2);
    chk("stall_count", stall_count, CNT_ON ? 32'd3 : 32'd0);
    chk("stall_fetch_count", fetch_count, CNT_ON ? 32'd2 : 32'd0);
    fetch(32'h2);
    chk("stall_resume_pc", imem_address, 32'h3);

    // Branch with stall at pc=1 to target 4.
    do_rst();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch(32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    chk("branch_pc", imem_address, 32'h4);
    chk("branch_state", 32'(state_dbg), 32'(RUN));
    fetch(32'h4);

    // Branch at LAST_PC suppresses auto-halt.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    chk("branch_last_done", 32'(done), 32'h0);
    chk("branch_last_state", 32'(state_dbg), 32'(RUN));
    chk("branch_last_pc", imem_address, 32'h2);
    fetch(32'h2);

    // halt_req beats start at pc=3; start resumes from pc=3.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0002, 32'h2);
    chk("halt_state", 32'(state_dbg), 32'(HALT));
    chk("halt_pc", imem_address, 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0002, 32'h2);
    chk("halt_stays", 32'(state_dbg), 32'(HALT));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0002, 32'h2);
    chk("resume_state", 32'(state_dbg), 32'(RUN));
    fetch(32'h3);
    chk("pre_rst_pc", imem_address, 32'h4);

    // Reset mid-run at pc=4.
    do_rst();
    chk("midrst_pc", imem_address, 32'h0);
    chk("midrst_state", 32'(state_dbg), 32'(IDLE));
    chk("midrst_fetch_count", fetch_count, 32'h0);
    chk("midrst_stall_count", stall_count, 32'h0);
    chk("midrst_done", 32'(done), 32'h0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
